mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_pkg.sv | 49 ++++
 rtl/mdio_mdc_gen.sv | 39 +++
 rtl/mdio_master.sv | 199 +++++++++++++++++++
 tb/tb_mdio_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO master: register map, CTRL/CMD/STATUS field
// positions, frame FSM states and clause 22/45 start/opcode constants.
package mdio_pkg;

    localparam logic [9:0] ADDR_CTRL   = 10'h000;
    localparam logic [9:0] ADDR_CMD    = 10'h004;
    localparam logic [9:0] ADDR_WDATA  = 10'h008;
    localparam logic [9:0] ADDR_RDATA  = 10'h00C;
    localparam logic [9:0] ADDR_STATUS = 10'h010;
    localparam logic [9:0] ADDR_CLKDIV = 10'h014;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_PRE_SUP = 2;

    localparam int unsigned CMD_ST_LSB    = 0;
    localparam int unsigned CMD_OP_LSB    = 2;
    localparam int unsigned CMD_PRTAD_LSB = 4;
    localparam int unsigned CMD_DEVAD_LSB = 9;

    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_DONE   = 1;
    localparam int unsigned STAT_TA_ERR = 2;

    localparam logic [1:0] ST_C22       = 2'b01;
    localparam logic [1:0] ST_C45       = 2'b00;
    localparam logic [1:0] OP_C22_WRITE = 2'b01;
    localparam logic [1:0] OP_C22_READ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA
    } mdio_state_e;

    // Index of the final bit of each frame phase.
    function automatic logic [5:0] last_bit(input mdio_state_e s);
        case (s)
            S_PRE:   return 6'd31;
            S_HDR:   return 6'd13;
            S_TA:    return 6'd1;
            S_DATA:  return 6'd15;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC generator: low half then high half, each div+1 clocks, with strobes that
// flag the clock edge on which MDC will rise or fall. Held low while disabled.
import mdio_pkg::*;

module mdio_mdc_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             mdc,
    output logic             rise,
    output logic             fall
);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap = en && (cnt == div);
    assign rise = wrap && !mdc;
    assign fall = wrap && mdc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// APB3-programmed MDIO management master (clause 22/45 frames).
// Preamble suppression (CTRL.PRE_SUP) exists only when MDIO_MASTER_PRE_SUP_EN is defined.
import mdio_pkg::*;

module mdio_master #(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 19
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [9:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        MDC,
    output logic        MDIO_out,
    output logic        mdio_oe,
    input  logic        MDIO_in,
    output logic        MDIO_irq
);

    logic             irq_en;
    logic             pre_sup;
    logic [13:0]      cmd;
    logic [15:0]      wdata;
    logic [15:0]      rdata;
    logic [15:0]      rd_shift;
    logic [DIV_W-1:0] clkdiv;
    logic             done;
    logic             ta_err;
    logic             busy;
    mdio_state_e      state;
    logic [5:0]       bit_cnt;

    logic             wr_en;
    logic             rd_setup;
    logic             start_req;
    logic             is_read;
    logic [13:0]      hdr;
    logic             mdc_rise;
    logic             mdc_fall;
    logic [31:0]      rd_mux;
    mdio_state_e      nxt_state;
    logic [5:0]       nxt_cnt;
    logic             nxt_bit;
    logic             nxt_oe;
    logic             unused_pwdata;

    assign unused_pwdata = ^PWDATA[31:16];

    assign wr_en     = PSEL && PENABLE && PWRITE;
    assign rd_setup  = PSEL && !PENABLE && !PWRITE;
    assign busy      = (state != S_IDLE);
    assign start_req = wr_en && (PADDR == ADDR_CTRL) && PWDATA[CTRL_START] && !busy;
    assign is_read   = cmd[CMD_OP_LSB + 1];
    assign hdr       = {cmd[CMD_ST_LSB +: 2], cmd[CMD_OP_LSB +: 2],
                        cmd[CMD_PRTAD_LSB +: 5], cmd[CMD_DEVAD_LSB +: 5]};
    assign MDIO_irq  = done && irq_en;

    mdio_mdc_gen #(
        .DIV_W (DIV_W)
    ) u_mdc_gen (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .en    (busy),
        .div   (clkdiv),
        .mdc   (MDC),
        .rise  (mdc_rise),
        .fall  (mdc_fall)
    );

`ifdef MDIO_MASTER_PRE_SUP_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            pre_sup <= 1'b0;
        else if (wr_en && (PADDR == ADDR_CTRL))
            pre_sup <= PWDATA[CTRL_PRE_SUP];
    end
`else
    assign pre_sup = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (PADDR)
            ADDR_CTRL: begin
                rd_mux[CTRL_IRQ_EN]  = irq_en;
                rd_mux[CTRL_PRE_SUP] = pre_sup;
            end
            ADDR_CMD:    rd_mux[13:0] = cmd;
            ADDR_WDATA:  rd_mux[15:0] = wdata;
            ADDR_RDATA:  rd_mux[15:0] = rdata;
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY]   = busy;
                rd_mux[STAT_DONE]   = done;
                rd_mux[STAT_TA_ERR] = ta_err;
            end
            ADDR_CLKDIV: rd_mux[DIV_W-1:0] = clkdiv;
            default:     rd_mux = '0;
        endcase
    end

    // PRDATA is captured in the setup phase so it is stable for the zero-wait access phase.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_en <= 1'b0;
            cmd    <= '0;
            wdata  <= '0;
            clkdiv <= DIV_W'(DIV_RST);
            PRDATA <= '0;
        end else begin
            if (wr_en) begin
                case (PADDR)
                    ADDR_CTRL:   irq_en <= PWDATA[CTRL_IRQ_EN];
                    ADDR_CMD:    if (!busy) cmd    <= PWDATA[13:0];
                    ADDR_WDATA:  if (!busy) wdata  <= PWDATA[15:0];
                    ADDR_CLKDIV: if (!busy) clkdiv <= PWDATA[DIV_W-1:0];
                    default: ;
                endcase
            end
            if (rd_setup)
                PRDATA <= rd_mux;
        end
    end

    // Position and pad values of the bit that begins at the next MDC fall.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = bit_cnt + 6'd1;
        if (bit_cnt == last_bit(state)) begin
            nxt_cnt = '0;
            case (state)
                S_PRE:   nxt_state = S_HDR;
                S_HDR:   nxt_state = S_TA;
                S_TA:    nxt_state = S_DATA;
                default: nxt_state = S_IDLE;
            endcase
        end
        case (nxt_state)
            S_HDR:   nxt_bit = hdr[4'd13 - nxt_cnt[3:0]];
            S_TA:    nxt_bit = ~nxt_cnt[0];
            S_DATA:  nxt_bit = wdata[4'd15 - nxt_cnt[3:0]];
            default: nxt_bit = 1'b1;
        endcase
        nxt_oe = (nxt_state != S_IDLE) &&
                 !(is_read && ((nxt_state == S_TA) || (nxt_state == S_DATA)));
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            MDIO_out <= 1'b1;
            mdio_oe  <= 1'b0;
            rd_shift <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            ta_err   <= 1'b0;
        end else begin
            if (wr_en && (PADDR == ADDR_STATUS)) begin
                if (PWDATA[STAT_DONE])   done   <= 1'b0;
                if (PWDATA[STAT_TA_ERR]) ta_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state    <= pre_sup ? S_HDR : S_PRE;
                        bit_cnt  <= '0;
                        mdio_oe  <= 1'b1;
                        MDIO_out <= pre_sup ? hdr[13] : 1'b1;
                    end
                end
                default: begin
                    if (mdc_rise && is_read) begin
                        if ((state == S_TA) && bit_cnt[0] && MDIO_in)
                            ta_err <= 1'b1;
                        if (state == S_DATA)
                            rd_shift <= {rd_shift[14:0], MDIO_in};
                    end
                    // Set updates come after the W1C so a completing frame wins.
                    if (mdc_fall) begin
                        state    <= nxt_state;
                        bit_cnt  <= nxt_cnt;
                        MDIO_out <= nxt_bit;
                        mdio_oe  <= nxt_oe;
                        if (nxt_state == S_IDLE) begin
                            done <= 1'b1;
                            if (is_read)
                                rdata <= rd_shift;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: a cycle-timeline frame model checked every
// cycle, plus directed register and serial-stream expectations.
module tb_mdio_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        MDC, MDIO_out, mdio_oe, MDIO_in, MDIO_irq;

    int total = 0;
    int bad   = 0;

    always #5 PCLK = ~PCLK;

    mdio_master #(
        .DIV_W   (8),
        .DIV_RST (19)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .MDC      (MDC),
        .MDIO_out (MDIO_out),
        .mdio_oe  (mdio_oe),
        .MDIO_in  (MDIO_in),
        .MDIO_irq (MDIO_irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy = 0, m_done = 0, m_ta_err = 0, m_irq_en = 0, m_pre_sup = 0;
    int          m_div = 19;
    logic [13:0] m_cmd = '0;
    logic [15:0] m_wdata = '0, m_rdata = '0;
    int          m_cyc = 0, m_nbits = 0;
    bit          f_bit[64];
    bit          f_oe[64];
    logic [15:0] resp_word = 16'hFFFF;
    bit          resp_ta1 = 1;

    function automatic bit m_is_read();
        return m_cmd[3];
    endfunction

    task automatic build_frame();
        int n = 0;
        logic [13:0] h;
        h = {m_cmd[1:0], m_cmd[3:2], m_cmd[8:4], m_cmd[13:9]};
        if (!m_pre_sup)
            for (int i = 0; i < 32; i++) begin f_bit[n] = 1; f_oe[n] = 1; n++; end
        for (int i = 13; i >= 0; i--) begin f_bit[n] = h[i]; f_oe[n] = 1; n++; end
        f_bit[n] = 1; f_oe[n] = !m_is_read(); n++;
        f_bit[n] = 0; f_oe[n] = !m_is_read(); n++;
        for (int i = 15; i >= 0; i--) begin f_bit[n] = m_wdata[i]; f_oe[n] = !m_is_read(); n++; end
        m_nbits = n;
    endtask

    always @(posedge PCLK or negedge PRESETn) begin : model
        bit b0;
        int p2;
        if (!PRESETn) begin
            m_busy = 0; m_done = 0; m_ta_err = 0; m_irq_en = 0; m_pre_sup = 0;
            m_div = 19; m_cmd = '0; m_wdata = '0; m_rdata = '0; m_cyc = 0;
        end else begin
            b0 = m_busy;
            if (PSEL && PENABLE && PWRITE) begin
                case (PADDR)
                    10'h000: begin
                        m_irq_en = PWDATA[1];
`ifdef MDIO_MASTER_PRE_SUP_EN
                        m_pre_sup = PWDATA[2];
`endif
                        if (PWDATA[0] && !b0) begin
                            m_busy = 1; m_cyc = 0; build_frame();
                        end
                    end
                    10'h004: if (!b0) m_cmd = PWDATA[13:0];
                    10'h008: if (!b0) m_wdata = PWDATA[15:0];
                    10'h014: if (!b0) m_div = int'(PWDATA[7:0]);
                    10'h010: begin
                        if (PWDATA[1]) m_done = 0;
                        if (PWDATA[2]) m_ta_err = 0;
                    end
                    default: ;
                endcase
            end
            if (b0) begin
                m_cyc++;
                p2 = 2 * (m_div + 1);
                if (m_is_read() && resp_ta1 && m_cyc == (m_nbits - 17) * p2 + m_div + 1)
                    m_ta_err = 1;
                if (m_cyc == m_nbits * p2) begin
                    m_busy = 0; m_done = 1;
                    if (m_is_read()) m_rdata = resp_word;
                end
            end
        end
    end

    function automatic logic [31:0] m_reg(input logic [9:0] a);
        case (a)
            10'h000: return {29'b0, m_pre_sup, m_irq_en, 1'b0};
            10'h004: return {18'b0, m_cmd};
            10'h008: return {16'b0, m_wdata};
            10'h00C: return {16'b0, m_rdata};
            10'h010: return {29'b0, m_ta_err, m_done, m_busy};
            10'h014: return m_div;
            default: return 32'h0;
        endcase
    endfunction

    // Per-cycle compare of pad outputs, plus the PHY responder.
    always @(negedge PCLK) begin : compare
        bit e_mdc, e_out, e_oe;
        int p2, b, ta0;
        e_mdc = 0; e_out = 1; e_oe = 0; b = 0;
        p2 = 2 * (m_div + 1);
        if (m_busy) begin
            b = m_cyc / p2;
            e_mdc = (m_cyc % p2) >= (m_div + 1);
            e_out = f_bit[b];
            e_oe  = f_oe[b];
        end
        chk("mdc", MDC, e_mdc);
        chk("oe", mdio_oe, e_oe);
        if (e_oe) chk("mdio_out", MDIO_out, e_out);
        chk("irq", MDIO_irq, m_done && m_irq_en);
        ta0 = m_nbits - 18;
        if (m_busy && m_is_read() && b == ta0 + 1)     MDIO_in = resp_ta1;
        else if (m_busy && m_is_read() && b >= ta0 + 2) MDIO_in = resp_word[15 - (b - ta0 - 2)];
        else                                           MDIO_in = 1'b1;
    end

    // Frame measurement taken from the DUT pins.
    int          cyc_n = 0, t_rise = 0, t_fall = 0;
    bit          prev_oe = 0, prev_mdc = 0, first_bit = 0;
    logic [63:0] cap = '0;
    always @(posedge PCLK) cyc_n++;
    always @(negedge PCLK) begin
        if (mdio_oe && !prev_oe) begin t_rise = cyc_n; first_bit = MDIO_out; cap = '0; end
        if (!mdio_oe && prev_oe) t_fall = cyc_n;
        if (MDC && !prev_mdc) cap = {cap[62:0], MDIO_out};
        prev_oe = mdio_oe; prev_mdc = MDC;
    end

    // ---------------- stimulus ----------------
    task automatic apb_write(input logic [9:0] a, input logic [31:0] d);
        @(posedge PCLK); #1 PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1 PENABLE = 1;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [9:0] a, output logic [31:0] d);
        @(posedge PCLK); #1 PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
        @(posedge PCLK); #1 PENABLE = 1; d = PRDATA;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
    endtask

    task automatic rd_chk(input string name, input logic [9:0] a, input logic [31:0] lit);
        logic [31:0] d;
        apb_read(a, d);
        chk({name, "_model"}, d, m_reg(a));
        chk(name, d, lit);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 5000) begin @(posedge PCLK); n++; end
        if (m_busy) begin
            total++; bad++;
            $display("FAIL wait_idle: frame still busy after %0d cycles", n);
        end
        repeat (3) @(posedge PCLK);
    endtask

    localparam logic [31:0] CMD_WR = 32'h655;  // ST=01 OP=01 PRTAD=5 REGAD=3
    localparam logic [31:0] CMD_RD = 32'h659;  // ST=01 OP=10 PRTAD=5 REGAD=3

`ifdef MDIO_MASTER_PRE_SUP_EN
    localparam int          PS_LEN   = 128;
    localparam bit          PS_FIRST = 0;
    localparam logic [31:0] PS_CTRL  = 32'h4;
`else
    localparam int          PS_LEN   = 256;
    localparam bit          PS_FIRST = 1;
    localparam logic [31:0] PS_CTRL  = 32'h0;
`endif

    initial begin
        int n;
        PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0; MDIO_in = 1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_mdc", MDC, 0);
        chk("rst_out", MDIO_out, 1);
        chk("rst_oe", mdio_oe, 0);
        chk("rst_irq", MDIO_irq, 0);
        chk("rst_prdata", PRDATA, 0);
        @(posedge PCLK); #1 PRESETn = 1;
        rd_chk("rst_clkdiv", 10'h014, 32'd19);
        rd_chk("rst_status", 10'h010, 32'h0);
        rd_chk("rst_cmd", 10'h004, 32'h0);
        rd_chk("unmapped", 10'h020, 32'h0);

        // PRE_SUP bit is only storable when the feature is built in
        apb_write(10'h000, 32'h4);
        rd_chk("ctrl_presup", 10'h000, PS_CTRL);
        apb_write(10'h000, 32'h0);

        // Clause 22 write frame
        apb_write(10'h014, 32'd1);
        apb_write(10'h004, CMD_WR);
        apb_write(10'h008, 32'hA5C3);
        apb_write(10'h000, 32'h1);
        wait_idle();
        chk("wr_len", t_fall - t_rise, 256);
        chk("wr_stream_hi", cap[63:32], 32'hFFFF_FFFF);
        chk("wr_stream_lo", cap[31:0], 32'h528E_A5C3);
        rd_chk("wr_status", 10'h010, 32'h2);
        apb_write(10'h010, 32'h2);

        // Clause 22 read frame, good turnaround
        resp_ta1 = 0; resp_word = 16'h1234;
        apb_write(10'h004, CMD_RD);
        apb_write(10'h000, 32'h1);
        wait_idle();
        chk("rd_oe_len", t_fall - t_rise, 46 * 4);
        rd_chk("rd_rdata", 10'h00C, 32'h1234);
        rd_chk("rd_status", 10'h010, 32'h2);
        apb_write(10'h010, 32'h2);

        // Read with MDIO_in stuck high
        resp_ta1 = 1; resp_word = 16'hFFFF;
        apb_write(10'h000, 32'h1);
        wait_idle();
        rd_chk("rderr_rdata", 10'h00C, 32'hFFFF);
        rd_chk("rderr_status", 10'h010, 32'h6);
        apb_write(10'h010, 32'h6);
        rd_chk("rderr_w1c", 10'h010, 32'h0);

        // Writes during a busy frame are ignored; IRQ_EN still takes effect
        apb_write(10'h004, CMD_WR);
        apb_write(10'h008, 32'h0F0F);
        apb_write(10'h000, 32'h1);
        repeat (20) @(posedge PCLK);
        apb_write(10'h000, 32'h3);
        apb_write(10'h014, 32'd7);
        apb_write(10'h008, 32'h1111);
        rd_chk("busy_status", 10'h010, 32'h1);
        rd_chk("busy_clkdiv", 10'h014, 32'd1);
        wait_idle();
        chk("busy_len", t_fall - t_rise, 256);
        chk("busy_stream_lo", cap[31:0], 32'h528E_0F0F);
        chk("irq_at_done", MDIO_irq, 1);
        apb_write(10'h010, 32'h2);
        #1 chk("irq_cleared", MDIO_irq, 0);
        apb_write(10'h000, 32'h0);

        // Reset in the middle of the data phase
        apb_write(10'h008, 32'hA5C3);
        apb_write(10'h000, 32'h1);
        n = 0;
        while (!(m_busy && m_cyc >= 200) && n < 2000) begin @(posedge PCLK); n++; end
        #2 PRESETn = 0;
        #1;
        chk("midrst_mdc", MDC, 0);
        chk("midrst_oe", mdio_oe, 0);
        chk("midrst_out", MDIO_out, 1);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1;
        rd_chk("midrst_status", 10'h010, 32'h0);
        rd_chk("midrst_clkdiv", 10'h014, 32'd19);
        apb_write(10'h014, 32'd1);
        apb_write(10'h004, CMD_WR);
        apb_write(10'h008, 32'hA5C3);
        apb_write(10'h000, 32'h1);
        wait_idle();
        chk("postrst_len", t_fall - t_rise, 256);
        chk("postrst_stream_lo", cap[31:0], 32'h528E_A5C3);
        apb_write(10'h010, 32'h2);

        // Preamble suppression (frame shrinks only when the feature is built)
        apb_write(10'h000, 32'h4);
        apb_write(10'h000, 32'h5);
        wait_idle();
        chk("presup_len", t_fall - t_rise, PS_LEN);
        chk("presup_first", first_bit, PS_FIRST);
        chk("presup_stream_lo", cap[31:0], 32'h528E_A5C3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
